// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and tile geometry, shared with the level map.
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV    = 4;
  localparam int unsigned DEF_H_TOTAL    = 800;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_START    = 144;
  localparam int unsigned DEF_H_END      = 784;
  localparam int unsigned DEF_V_TOTAL    = 525;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_START    = 35;
  localparam int unsigned DEF_V_END      = 515;
  localparam int unsigned DEF_TILE_SHIFT = 5;

  localparam int unsigned COUNT_W    = 10;
  localparam int unsigned FRAME_W    = 8;
  localparam int unsigned TILE_COL_W = 5;
  localparam int unsigned TILE_ROW_W = 4;

  localparam int unsigned TILES_X = (DEF_H_END - DEF_H_START) >> DEF_TILE_SHIFT;
  localparam int unsigned TILES_Y = (DEF_V_END - DEF_V_START) >> DEF_TILE_SHIFT;

  // Tile index of a raster position relative to the visible-window origin (modulo 2^COUNT_W).
  function automatic logic [COUNT_W-1:0] tileIndex(input logic [COUNT_W-1:0] pos,
                                                   input logic [COUNT_W-1:0] start,
                                                   input int unsigned shift);
    return (pos - start) >> shift;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to the pixel rate: combinational tick plus a registered pixelEn.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_c,
  output logic pixelEn
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] divider;

  assign tick_c = (divider == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divider <= '0;
      pixelEn <= 1'b0;
    end else begin
      divider <= tick_c ? '0 : divider + DIV_W'(1);
      pixelEn <= tick_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel counters, syncs, visible window, tile coordinates and frame count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL    = DEF_H_TOTAL,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_START    = DEF_H_START,
  parameter int unsigned H_END      = DEF_H_END,
  parameter int unsigned V_TOTAL    = DEF_V_TOTAL,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_START    = DEF_V_START,
  parameter int unsigned V_END      = DEF_V_END,
  parameter int unsigned TILE_SHIFT = DEF_TILE_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  pixelEn,
  output logic [COUNT_W-1:0]    hCount,
  output logic [COUNT_W-1:0]    vCount,
  output logic                  hSync,
  output logic                  vSync,
  output logic                  bright,
  output logic                  frameStart,
  output logic [TILE_COL_W-1:0] tileCol,
  output logic [TILE_ROW_W-1:0] tileRow,
  output logic [FRAME_W-1:0]    frameCount
);

  logic                  tick_c;
  logic [COUNT_W-1:0]    hNext;
  logic [COUNT_W-1:0]    vNext;
  logic [FRAME_W-1:0]    frameNext;
  logic                  frameStartNext;
  logic                  hSyncNext;
  logic                  vSyncNext;
  logic                  brightNext;
  logic [TILE_COL_W-1:0] tileColNext;
  logic [TILE_ROW_W-1:0] tileRowNext;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_c  (tick_c),
    .pixelEn (pixelEn)
  );

  // Next raster position; every other output is derived from it so all stay aligned.
  always_comb begin
    hNext          = hCount;
    vNext          = vCount;
    frameNext      = frameCount;
    frameStartNext = 1'b0;
    if (tick_c) begin
      if (hCount == COUNT_W'(H_TOTAL - 1)) begin
        hNext = '0;
        if (vCount == COUNT_W'(V_TOTAL - 1)) begin
          vNext          = '0;
          frameNext      = frameCount + FRAME_W'(1);
          frameStartNext = 1'b1;
        end else begin
          vNext = vCount + COUNT_W'(1);
        end
      end else begin
        hNext = hCount + COUNT_W'(1);
      end
    end

    hSyncNext  = (hNext >= COUNT_W'(H_SYNC));
    vSyncNext  = (vNext >= COUNT_W'(V_SYNC));
    brightNext = (hNext >= COUNT_W'(H_START)) && (hNext < COUNT_W'(H_END)) &&
                 (vNext >= COUNT_W'(V_START)) && (vNext < COUNT_W'(V_END));
    tileColNext = '0;
    tileRowNext = '0;
    if (brightNext) begin
      tileColNext = TILE_COL_W'(tileIndex(hNext, COUNT_W'(H_START), TILE_SHIFT));
      tileRowNext = TILE_ROW_W'(tileIndex(vNext, COUNT_W'(V_START), TILE_SHIFT));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hCount     <= '0;
      vCount     <= '0;
      frameCount <= '0;
      frameStart <= 1'b0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      tileCol    <= '0;
      tileRow    <= '0;
    end else begin
      hCount     <= hNext;
      vCount     <= vNext;
      frameCount <= frameNext;
      frameStart <= frameStartNext;
      hSync      <= hSyncNext;
      vSync      <= vSyncNext;
      bright     <= brightNext;
      tileCol    <= tileColNext;
      tileRow    <= tileRowNext;
    end
  end

endmodule
